// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the HI/LO registers.
// One shift-add or restoring-divide step per cycle, 32 steps, then a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       fnctn,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] rs_raw_q, rs_raw_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_out_q, dbz_out_d;

  logic             valid_op;
  logic             signed_op;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] product;

  always_comb begin
    valid_op  = (fnctn[5:2] == 4'b0110);
    signed_op = ~fnctn[0];
    rs_neg    = signed_op & rs_val[WIDTH-1];
    rt_neg    = signed_op & rt_val[WIDTH-1];
    // Negating 0x8000_0000 wraps to itself, which is the correct unsigned magnitude.
    rs_mag    = rs_neg ? (~rs_val + 1'b1) : rs_val;
    rt_mag    = rt_neg ? (~rt_val + 1'b1) : rt_val;

    // Multiply: rem holds the running high half, quo shifts the multiplier out LSB first.
    mul_sum   = {1'b0, rem_q} + {1'b0, (quo_q[0] ? b_q : {WIDTH{1'b0}})};
    // Divide: top bit of the difference is set exactly when the trial subtract underflows.
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    product   = {rem_q, quo_q};

    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    rs_raw_d  = rs_raw_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && valid_op) begin
          state_d   = RUN;
          cnt_d     = '0;
          busy_d    = 1'b1;
          is_div_d  = fnctn[1];
          neg_d     = rs_neg ^ rt_neg;
          neg_rem_d = rs_neg;
          dbz_d     = fnctn[1] && (rt_val == '0);
          rs_raw_d  = rs_val;
          rem_d     = '0;
          quo_d     = fnctn[1] ? rs_mag : rt_mag;
          b_d       = fnctn[1] ? rt_mag : rs_mag;
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            rem_d = div_diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          rem_d = mul_sum[WIDTH:1];
          quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_q ? (~product + 1'b1) : product;
        end else if (dbz_q) begin
          hi_d = rs_raw_q;
          lo_d = '1;
        end else begin
          lo_d = neg_q     ? (~quo_q + 1'b1) : quo_q;
          hi_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end
        done_d    = 1'b1;
        dbz_out_d = dbz_q;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      rs_raw_q  <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      rs_raw_q  <= rs_raw_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
